lane_scroller: RTL and testbench
================================

// Module: lane_scroller
// PURPOSE
//  Generic N-lane horizontal scroller for river logs and road traffic. Each lane carries
//  OBJS_PER_LANE equally spaced objects that move 1 px per lane tick, left or right, and
//  wrap across the playfield. Runtime per-lane direction, length and speed; global pause
//  and difficulty speed-up; restart pulse. Feeds the renderer and collision/carry logic.
// PARAMETERS
//  NUM_LANES      6    number of lanes
//  OBJS_PER_LANE  2    objects per lane
//  X_W            10   x-coordinate / length width (bits)
//  DIV_W          24   speed-divider / counter width (bits)
//  X_LEFT         96   left playfield edge (px); must be >= max lane length
//  X_RIGHT        544  right playfield edge (px)
//  OBJ_SPACING    300  initial x spacing between consecutive objects in a lane (px)
// PORTS
//  clk          in   1                       system clock
//  reset_n      in   1                       synchronous, active-low reset
//  restart      in   1                       1-cycle pulse: re-init as reset (sync, active-high)
//  run          in   1                       1 = move, 0 = pause (counters and positions hold)
//  speed_shift  in   3                       difficulty: effective divider = lane_div >> speed_shift
//  lane_dir     in   NUM_LANES               per lane: 1 = right, 0 = left (latched at init)
//  lane_len     in   NUM_LANES*X_W           per-lane object length (px), latched at init
//  lane_div     in   NUM_LANES*DIV_W         per-lane speed divider, sampled live
//  obj_x        out  NUM_LANES*OBJS_PER_LANE*X_W  object left x; index (lane*OBJS_PER_LANE+k)*X_W
//  obj_len      out  NUM_LANES*X_W           latched lane length
//  lane_step    out  NUM_LANES*2             signed per-lane move this cycle: -1/0/+1 (carry)
// BEHAVIOUR
//  Init (reset_n=0 or restart=1; reset_n has priority; both take effect at the next clk edge):
//   obj_x[l][k] = X_LEFT + k*OBJ_SPACING (mod 2^X_W); all counters = 0; lane_step = 0;
//   obj_len and internal dir latch lane_len / lane_dir. Init applies regardless of run.
//  Per lane, each cycle with run=1:
//   eff = lane_div[l] >> speed_shift. If cnt >= eff: tick (cnt <= 0), else cnt <= cnt+1.
//   Tick period = eff+1 cycles; eff = 0 -> tick every cycle.
//   lane_div lowered below current cnt -> tick on the next cycle (>= compare), no lock-up.
//  On tick, for every object k of lane l (all objects updated in the same cycle):
//   left:  if x <= X_LEFT - len then x <= X_RIGHT else x <= x - 1
//   right: if x >= X_RIGHT      then x <= X_LEFT - len else x <= x + 1
//   Unsigned X_W compares; X_LEFT - len never underflows (constraint above).
//  lane_step: registered; = +1 (2'b01) or -1 (2'b11) in exactly the cycle obj_x shows the
//   moved value, 0 otherwise. Never nonzero while run=0 or during init.
//  run=0: cnt, obj_x held; lane_step = 0. Resume continues from held cnt (no lost count).
//  lane_dir / lane_len changes outside init are ignored until next reset/restart.
//  Lanes fully independent; simultaneous ticks on all lanes legal.
//  restart mid-tick: init wins; no move applied that cycle.
//  All outputs registered; no combinational input->output path.
// TESTING
//  1 Reset: hold reset_n=0 2 cycles -> lane l obj_x = {96, 396}, lane_step = 0, cnt = 0.
//  2 Rate: lane0 left, div=3, shift=0, run=1 -> obj0 x 96->95 at cycle 4, 94 at cycle 8;
//    lane_step[0] = -1 only on cycles 4, 8.
//  3 Wrap: lane1 right, len=96, x forced to 544 via run -> next tick x = 0 (96-96), then 1;
//    left lane len=64 at x=32 -> next tick x = 544.
//  4 Pause/speed: div=7, toggle run=0 for 5 cycles mid-count -> tick delayed exactly 5
//    cycles; shift=1 -> period 4 cycles (eff=3); div=0 -> moves every cycle.
//  5 Live div change: cnt=10, div 20->5 -> tick next cycle, then period 6.
//  6 Restart mid-operation: pulse restart on a tick cycle with new lane_dir/lane_len ->
//    positions back to init, no step pulse, new dir/len take effect; reset_n=0 with
//    restart=1 gives identical result.

Source files
------------

// File: rtl/lane_scroller.sv
// N-lane horizontal scroller: each lane moves its equally spaced objects one pixel
// per lane tick, left or right, wrapping across the playfield edges.
module lane_scroller #(
    parameter int NUM_LANES     = 6,
    parameter int OBJS_PER_LANE = 2,
    parameter int X_W           = 10,
    parameter int DIV_W         = 24,
    parameter int X_LEFT        = 96,
    parameter int X_RIGHT       = 544,
    parameter int OBJ_SPACING   = 300
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   restart,
    input  logic                                   run,
    input  logic [2:0]                             speed_shift,
    input  logic [NUM_LANES-1:0]                   lane_dir,
    input  logic [NUM_LANES*X_W-1:0]               lane_len,
    input  logic [NUM_LANES*DIV_W-1:0]             lane_div,
    output logic [NUM_LANES*OBJS_PER_LANE*X_W-1:0] obj_x,
    output logic [NUM_LANES*X_W-1:0]               obj_len,
    output logic [NUM_LANES*2-1:0]                 lane_step
);

    function automatic logic [X_W-1:0] init_x(input int k);
        return X_W'(X_LEFT + k * OBJ_SPACING);
    endfunction

    genvar gi, gk;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [DIV_W-1:0] cnt_q, cnt_d, eff;
            logic             dir_q, dir_d;
            logic [X_W-1:0]   len_q, len_d;
            logic [1:0]       step_q, step_d;
            logic [X_W-1:0]   x_q [OBJS_PER_LANE];
            logic [X_W-1:0]   x_d [OBJS_PER_LANE];
            logic             tick;
            logic [X_W-1:0]   wrap_lo;

            always_comb begin
                eff     = lane_div[gi*DIV_W +: DIV_W] >> speed_shift;
                // >= rather than == so a divider lowered below cnt ticks next cycle
                tick    = run && (cnt_q >= eff);
                wrap_lo = X_W'(X_LEFT) - len_q;
                cnt_d   = cnt_q;
                dir_d   = dir_q;
                len_d   = len_q;
                step_d  = 2'b00;
                for (int k = 0; k < OBJS_PER_LANE; k++) begin
                    x_d[k] = x_q[k];
                end
                if (restart) begin
                    cnt_d = '0;
                    dir_d = lane_dir[gi];
                    len_d = lane_len[gi*X_W +: X_W];
                    for (int k = 0; k < OBJS_PER_LANE; k++) begin
                        x_d[k] = init_x(k);
                    end
                end else if (tick) begin
                    cnt_d  = '0;
                    step_d = dir_q ? 2'b01 : 2'b11;
                    for (int k = 0; k < OBJS_PER_LANE; k++) begin
                        if (dir_q) begin
                            x_d[k] = (x_q[k] >= X_W'(X_RIGHT)) ? wrap_lo : x_q[k] + X_W'(1);
                        end else begin
                            x_d[k] = (x_q[k] <= wrap_lo) ? X_W'(X_RIGHT) : x_q[k] - X_W'(1);
                        end
                    end
                end else if (run) begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    cnt_q  <= '0;
                    dir_q  <= lane_dir[gi];
                    len_q  <= lane_len[gi*X_W +: X_W];
                    step_q <= 2'b00;
                    for (int k = 0; k < OBJS_PER_LANE; k++) begin
                        x_q[k] <= init_x(k);
                    end
                end else begin
                    cnt_q  <= cnt_d;
                    dir_q  <= dir_d;
                    len_q  <= len_d;
                    step_q <= step_d;
                    for (int k = 0; k < OBJS_PER_LANE; k++) begin
                        x_q[k] <= x_d[k];
                    end
                end
            end

            for (gk = 0; gk < OBJS_PER_LANE; gk++) begin : g_obj
                assign obj_x[(gi*OBJS_PER_LANE+gk)*X_W +: X_W] = x_q[gk];
            end
            assign obj_len[gi*X_W +: X_W] = len_q;
            assign lane_step[gi*2 +: 2]   = step_q;
        end
    endgenerate

endmodule

// File: tb/tb_lane_scroller.sv
// Bench for lane_scroller: directed rate/wrap checks, then randomized traffic compared
// against a ring-arithmetic model of each lane.
module tb_lane_scroller;
    localparam int L      = 6;
    localparam int K      = 2;
    localparam int X_W    = 10;
    localparam int DIV_W  = 24;
    localparam int XL     = 96;
    localparam int XR     = 544;
    localparam int SPACE  = 300;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic                     restart;
    logic                     run;
    logic [2:0]               speed_shift;
    logic [L-1:0]             lane_dir;
    logic [L*X_W-1:0]         lane_len;
    logic [L*DIV_W-1:0]       lane_div;
    logic [L*K*X_W-1:0]       obj_x;
    logic [L*X_W-1:0]         obj_len;
    logic [L*2-1:0]           lane_step;

    int total = 0;
    int bad   = 0;

    // model state: positions live on a ring [XL-len, XR]
    int mx    [L][K];
    int mlen  [L];
    int mdir  [L];
    int msince[L];
    int mstep [L];

    lane_scroller #(
        .NUM_LANES(L), .OBJS_PER_LANE(K), .X_W(X_W), .DIV_W(DIV_W),
        .X_LEFT(XL), .X_RIGHT(XR), .OBJ_SPACING(SPACE)
    ) dut (
        .clk(clk), .reset_n(reset_n), .restart(restart), .run(run),
        .speed_shift(speed_shift), .lane_dir(lane_dir), .lane_len(lane_len),
        .lane_div(lane_div), .obj_x(obj_x), .obj_len(obj_len), .lane_step(lane_step)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_init();
        for (int l = 0; l < L; l++) begin
            for (int k = 0; k < K; k++) mx[l][k] = (XL + k * SPACE) % (1 << X_W);
            mlen[l]   = int'(lane_len[l*X_W +: X_W]);
            mdir[l]   = int'(lane_dir[l]);
            msince[l] = 0;
            mstep[l]  = 0;
        end
    endtask

    // Called just after a posedge, using the inputs that edge sampled.
    task automatic model_step();
        int eff, lo, ring;
        if (!reset_n || restart) begin
            model_init();
            return;
        end
        for (int l = 0; l < L; l++) begin
            mstep[l] = 0;
            if (run) begin
                eff = int'(lane_div[l*DIV_W +: DIV_W] >> speed_shift);
                msince[l]++;
                if (msince[l] > eff) begin
                    msince[l] = 0;
                    lo   = XL - mlen[l];
                    ring = XR - lo + 1;
                    mstep[l] = mdir[l] ? 1 : -1;
                    for (int k = 0; k < K; k++) begin
                        if (mdir[l]) mx[l][k] = lo + ((mx[l][k] - lo + 1) % ring);
                        else         mx[l][k] = lo + ((mx[l][k] - lo - 1 + ring) % ring);
                    end
                end
            end
        end
    endtask

    task automatic compare_model();
        logic [L*K*X_W-1:0] ex;
        logic [L*X_W-1:0]   el;
        logic [L*2-1:0]     es;
        for (int l = 0; l < L; l++) begin
            for (int k = 0; k < K; k++) ex[(l*K+k)*X_W +: X_W] = X_W'(mx[l][k]);
            el[l*X_W +: X_W] = X_W'(mlen[l]);
            es[l*2 +: 2]     = 2'(mstep[l]);
        end
        check_eq("obj_x", 128'(obj_x), 128'(ex));
        check_eq("obj_len", 128'(obj_len), 128'(el));
        check_eq("lane_step", 128'(lane_step), 128'(es));
    endtask

    task automatic do_cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_model();
    endtask

    initial begin
        reset_n     = 1'b0;
        restart     = 1'b0;
        run         = 1'b0;
        speed_shift = 3'd0;
        lane_dir    = 6'b000010;
        for (int l = 0; l < L; l++) lane_len[l*X_W +: X_W] = X_W'(96);
        lane_div    = '0;
        lane_div[0 +: DIV_W] = DIV_W'(3);

        do_cycle();
        do_cycle();
        check_eq("rst_l0k0", 128'(obj_x[0 +: X_W]), 128'(96));
        check_eq("rst_l0k1", 128'(obj_x[X_W +: X_W]), 128'(396));
        check_eq("rst_step", 128'(lane_step), 128'(0));
        $display("txn reset: obj_x l0 = %0d,%0d", obj_x[0 +: X_W], obj_x[X_W +: X_W]);

        reset_n = 1'b1;
        run     = 1'b1;
        for (int n = 1; n <= 450; n++) begin
            do_cycle();
            if (n == 3) check_eq("rate_c3_step", 128'(lane_step[1:0]), 128'(0));
            if (n == 4) begin
                check_eq("rate_c4_x", 128'(obj_x[0 +: X_W]), 128'(95));
                check_eq("rate_c4_step", 128'(lane_step[1:0]), 128'(2'b11));
            end
            if (n == 8) check_eq("rate_c8_x", 128'(obj_x[0 +: X_W]), 128'(94));
            if (n == 448) check_eq("wrap_at_right", 128'(obj_x[2*X_W +: X_W]), 128'(544));
            if (n == 449) check_eq("wrap_to_lo", 128'(obj_x[2*X_W +: X_W]), 128'(0));
            if (n == 450) check_eq("wrap_then_1", 128'(obj_x[2*X_W +: X_W]), 128'(1));
        end
        $display("txn directed rate/wrap: lane1 obj0 x = %0d", obj_x[2*X_W +: X_W]);

        // pause mid-count: div=7 on lane0, freeze 5 cycles, tick must slip by 5
        restart = 1'b1;
        lane_div[0 +: DIV_W] = DIV_W'(7);
        do_cycle();
        restart = 1'b0;
        for (int n = 1; n <= 13; n++) begin
            run = !(n >= 4 && n <= 8);
            do_cycle();
            if (n == 8) check_eq("pause_no_tick", 128'(obj_x[0 +: X_W]), 128'(96));
            if (n == 13) check_eq("pause_tick", 128'(obj_x[0 +: X_W]), 128'(95));
        end
        run = 1'b1;
        $display("txn pause: lane0 obj0 x = %0d", obj_x[0 +: X_W]);

        for (int seg = 0; seg < 6; seg++) begin
            for (int n = 0; n < 500; n++) begin
                reset_n = ($urandom_range(0, 199) != 0);
                restart = ($urandom_range(0, 149) == 0);
                run     = ($urandom_range(0, 9) != 0);
                if ($urandom_range(0, 49) == 0) speed_shift = 3'($urandom_range(0, 7));
                lane_dir = L'($urandom);
                for (int l = 0; l < L; l++) begin
                    lane_len[l*X_W +: X_W] = X_W'($urandom_range(0, XL));
                    if ($urandom_range(0, 29) == 0)
                        lane_div[l*DIV_W +: DIV_W] = DIV_W'((seg % 2 == 0) ?
                            $urandom_range(0, 15) : $urandom_range(0, 60));
                end
                do_cycle();
            end
            $display("txn random segment %0d: total=%0d", seg, total);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
